gray_binary_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's combinational Gray-to-binary converter, for timestamp and counter paths in util_upack2_timestamp.
- Splits the WIDTH-long XOR chain across STAGES register stages to meet timing at wide widths.
- Adds a binary-to-Gray mode, valid/ready stream handshake with backpressure, and a sticky single-bit-step checker on the Gray input.

---
 rtl/gray_binary_pkg.sv | 17 +
 rtl/gray_chunk_stage.sv | 53 +++++
 rtl/gray_binary_pipe.sv | 101 ++++++++++
 tb/tb_gray_binary_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gray_binary_pkg.sv
// Shared constants and helpers for the pipelined Gray/binary converter.
package gray_binary_pkg;

  localparam int unsigned MODE_G2B  = 0;
  localparam int unsigned MODE_B2G  = 1;
  localparam int unsigned MAX_WIDTH = 256;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_gt1(input logic [MAX_WIDTH-1:0] d);
    return |(d & (d - MAX_WIDTH'(1)));
  endfunction

endpackage

// File: rtl/gray_chunk_stage.sv
// One pipeline stage: resolves binary bits HI..LO (Gray->binary) or does the
// whole binary->Gray step; an empty range (HI < LO) makes it a pure delay.
module gray_chunk_stage
  import gray_binary_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int          HI    = 31,
  parameter int          LO    = 0,
  parameter int unsigned MODE  = MODE_G2B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_bin,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray
);

  localparam bit Empty = (HI < LO);

  logic [WIDTH-1:0] bin_d;

  always_comb begin
    bin_d = in_bin;
    if (!Empty) begin
      if (MODE == MODE_B2G) begin
        bin_d = in_bin ^ (in_bin >> 1);
      end else begin
        if (HI == int'(WIDTH) - 1) bin_d[WIDTH-1] = in_gray[WIDTH-1];
        // Walk downward so each bit sees the already-resolved bit above it.
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
          if (i <= HI && i >= LO) bin_d[i] = in_gray[i] ^ bin_d[i+1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_gray  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_bin   <= bin_d;
      out_gray  <= in_gray;
    end
  end

endmodule

// File: rtl/gray_binary_pipe.sv
// Pipelined Gray<->binary converter with valid/ready handshake and a sticky
// Gray single-bit-step checker.
module gray_binary_pipe
  import gray_binary_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STAGES     = 4,
  parameter int unsigned MODE       = MODE_G2B,
  parameter int unsigned CHECK_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             step_err,
  input  logic             err_clr
);

  localparam int unsigned Ch      = ceil_div(WIDTH, (STAGES == 0) ? 1 : STAGES);
  localparam bit          CheckEn = (CHECK_STEP != 0) && (MODE == MODE_G2B);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("gray_binary_pipe: WIDTH out of range");
  end
  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("gray_binary_pipe: STAGES must be in 1..WIDTH");
  end

  logic             en;
  logic             valid_s [STAGES+1];
  logic [WIDTH-1:0] bin_s   [STAGES+1];
  logic [WIDTH-1:0] gray_s  [STAGES+1];

  // Whole pipe advances together; bubbles only collapse when the output is empty.
  assign en      = m_ready | ~m_valid;
  assign s_ready = en;

  assign valid_s[0] = s_valid;
  assign bin_s[0]   = (MODE == MODE_B2G) ? s_data : '0;
  assign gray_s[0]  = s_data;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int HiG = int'(WIDTH) - 1 - k * int'(Ch);
    localparam int LoG = int'(WIDTH) - (k + 1) * int'(Ch);
    localparam int Hi  = (MODE == MODE_B2G) ? ((k == 0) ? int'(WIDTH) - 1 : -1) : HiG;
    localparam int Lo  = (MODE == MODE_B2G) ? 0 : ((LoG < 0) ? 0 : LoG);

    gray_chunk_stage #(
      .WIDTH (WIDTH),
      .HI    (Hi),
      .LO    (Lo),
      .MODE  (MODE)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (valid_s[k]),
      .in_bin    (bin_s[k]),
      .in_gray   (gray_s[k]),
      .out_valid (valid_s[k+1]),
      .out_bin   (bin_s[k+1]),
      .out_gray  (gray_s[k+1])
    );
  end

  assign m_valid = valid_s[STAGES];
  assign m_data  = bin_s[STAGES];

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic             xfer;
  logic             step_bad;

  always_comb begin
    xfer     = s_valid & s_ready;
    step_bad = CheckEn && xfer && !first_q && popcount_gt1(MAX_WIDTH'(s_data ^ prev_q));
    err_d    = step_bad | (err_q & ~err_clr);
    prev_d   = xfer ? s_data : prev_q;
    first_d  = xfer ? 1'b0 : first_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '0;
      first_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign step_err = err_q;

endmodule

// File: tb/tb_gray_binary_pipe.sv
// Directed bench: Gray->binary (8b, 3 stages) and binary->Gray (8b, 2 stages).
module tb_gray_binary_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, m_valid, m_ready, step_err, err_clr;
  logic [7:0] s_data, m_data;
  logic       b_s_valid, b_s_ready, b_m_valid, b_step_err;
  logic [7:0] b_s_data, b_m_data;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  gray_binary_pipe #(.WIDTH(8), .STAGES(3), .MODE(0), .CHECK_STEP(1)) u_g2b (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .step_err (step_err),
    .err_clr  (err_clr)
  );

  gray_binary_pipe #(.WIDTH(8), .STAGES(2), .MODE(1), .CHECK_STEP(1)) u_b2g (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (b_s_valid),
    .s_ready  (b_s_ready),
    .s_data   (b_s_data),
    .m_valid  (b_m_valid),
    .m_ready  (1'b1),
    .m_data   (b_m_data),
    .step_err (b_step_err),
    .err_clr  (1'b0)
  );

  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         in_idx, out_idx, cyc;
    logic [7:0] held;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; err_clr = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; held = '0;
    #2;
    check_bit("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check_bit("rst_step_err", step_err, 1'b0);
    check_bit("rst_s_ready", s_ready, 1'b1);
    #12 rst = 1'b0;
    tick();

    // Direct conversion: Gray C0 -> binary 80, three-cycle latency.
    send(8'hC0);
    check_bit("lat_c1", m_valid, 1'b0);
    tick();
    check_bit("lat_c2", m_valid, 1'b0);
    tick();
    check_bit("lat_c3", m_valid, 1'b1);
    check("direct_c0", m_data, 8'h80);
    check_bit("direct_err", step_err, 1'b0);
    tick();
    check_bit("single_word", m_valid, 1'b0);

    rst = 1'b1;
    #1 rst = 1'b0;
    tick();

    // Full Gray count with wrap back to 0, backpressure in cycles 100..104.
    in_idx = 0; out_idx = 0; cyc = 0;
    while (out_idx < 257 && cyc < 600) begin
      m_ready = !(cyc >= 100 && cyc < 105);
      s_valid = (in_idx < 257);
      s_data  = bin2gray(8'(in_idx));
      @(negedge clk);
      if (!m_ready) begin
        check_bit("bp_s_ready", s_ready, 1'b0);
        check_bit("bp_m_valid", m_valid, 1'b1);
        if (cyc == 100) held = m_data;
        else check("bp_hold", m_data, held);
      end
      if (out_idx > 0 && out_idx < 257) check_bit("no_gap", m_valid, 1'b1);
      if (m_valid && m_ready) begin
        check("stream_data", m_data, 8'(out_idx));
        out_idx++;
      end
      if (s_valid && s_ready) in_idx++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check_bit("stream_done", out_idx == 257, 1'b1);
    check_bit("stream_err", step_err, 1'b0);

    // Step checker: repeat is legal, 00->03 is not; clear, then set beats clear.
    send(8'h00);
    check_bit("repeat_ok", step_err, 1'b0);
    send(8'h03);
    check_bit("step_set", step_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_bit("err_clr", step_err, 1'b0);
    s_valid = 1'b1; s_data = 8'h00; err_clr = 1'b1;
    tick();
    s_valid = 1'b0; err_clr = 1'b0;
    check_bit("set_wins", step_err, 1'b1);
    tick();
    check_bit("sticky", step_err, 1'b1);

    // Reset with three words in flight.
    send(8'h01);
    send(8'h00);
    send(8'h00);
    check_bit("inflight_valid", m_valid, 1'b1);
    check("inflight_data", m_data, 8'h01);
    rst = 1'b1;
    #1;
    check_bit("mid_rst_valid", m_valid, 1'b0);
    check("mid_rst_data", m_data, 8'h00);
    check_bit("mid_rst_err", step_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    send(8'h0F);
    check_bit("post_rst_first", step_err, 1'b0);
    tick();
    check_bit("post_rst_c2", m_valid, 1'b0);
    tick();
    check_bit("post_rst_valid", m_valid, 1'b1);
    check("post_rst_data", m_data, 8'h0A);

    // Binary -> Gray, two-cycle latency; checker is forced off in this mode.
    b_s_valid = 1'b1; b_s_data = 8'h80;
    tick();
    b_s_data = 8'hFF;
    tick();
    b_s_valid = 1'b0;
    check_bit("b2g_valid", b_m_valid, 1'b1);
    check("b2g_80", b_m_data, 8'hC0);
    tick();
    check("b2g_ff", b_m_data, 8'h80);
    check_bit("b2g_no_check", b_step_err, 1'b0);
    check_bit("b2g_s_ready", b_s_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
